alu_result_queue: RTL and testbench
===================================

// Module: alu_result_queue
// PURPOSE
//  Downstream stage of the 4-bit adder/subtractor. Captures each sum/difference and
//  carry_out, derives the Z/N/C/V status flags, and buffers {result,flags} in a small
//  FIFO. Consumers (register file / display) drain it through a valid/ready handshake.
//  The arithmetic stage stays purely combinational; back-pressure is absorbed here.
// PARAMETERS
//  WIDTH  4  data width; must match the adder/subtractor width
//  DEPTH  4  FIFO entries; power of two, >= 2
// PORTS
//  clk           in   1         single clock, rising edge
//  rst           in   1         asynchronous, active-high reset
//  in_valid      in   1         result/carry/operand MSBs valid this cycle
//  in_ready      out  1         queue accepts; push = in_valid & in_ready
//  in_result     in   WIDTH     adder_subtractor.out
//  in_carry      in   1         adder_subtractor.carry_out (raw; sub: 1 = no borrow)
//  in_sub        in   1         operation select that produced in_result (1 = a-b)
//  in_a_msb      in   1         a[WIDTH-1]
//  in_b_msb      in   1         b[WIDTH-1] before inversion
//  out_valid     out  1         head entry valid
//  out_ready     in   1         consumer accepts; pop = out_valid & out_ready
//  out_result    out  WIDTH     head result
//  out_flags     out  4         head flags {V,N,C,Z}
//  count         out  clog2(DEPTH)+1  entries held
//  sticky_v      out  1         set on any pushed entry with V=1
//  clr_sticky    in   1         synchronous clear of sticky_v
// BEHAVIOUR
//  Reset: pointers=0, count=0, out_valid=0, in_ready=1, sticky_v=0,
//   out_result=0, out_flags=0. Storage contents are not reset.
//  Flags are computed combinationally at push and stored with the result:
//   Z = (in_result == 0); N = in_result[WIDTH-1]; C = in_carry (not inverted for sub)
//   add: V = (a_msb == b_msb) & (N != a_msb)
//   sub: V = (a_msb != b_msb) & (N != a_msb)
//  Latency: a push is visible at out_* on the next cycle; no same-cycle bypass.
//  out_result/out_flags are driven from the head entry; they are 0 whenever out_valid=0.
//  in_ready = (count < DEPTH). Full queue rejects pushes even if a pop occurs that cycle.
//  Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
//  Push while empty with out_ready=1: no pop that cycle; entry appears next cycle.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty derive from count.
//  in_valid while in_ready=0: ignored; the upstream holds its operands.
//  sticky_v: clr_sticky wins over a same-cycle set; otherwise set on push with V=1.
//  Reset mid-operation discards every entry; out_valid drops asynchronously.
// STRUCTURE
//  Shared package alu_pkg: FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3 bit indices,
//   alu_flags_t typedef (4-bit packed struct {v,n,c,z}).
//  Sub-module alu_flag_gen (combinational): result, carry, sub, a_msb, b_msb -> flags.
//  Top: storage array, read/write pointers, count, sticky register.
// TESTING
//  1 add 0111+0001: result 1000, carry 0, sub 0 -> next cycle out 1000, flags V=1 N=1 C=0 Z=0
//  2 sub 0101-0101: result 0000, carry 1 -> flags Z=1 C=1 N=0 V=0; sub 0011-0101:
//    result 1110, carry 0 -> N=1 C=0 V=0
//  3 out_ready=0, push 5 entries -> 4 accepted, in_ready=0 after 4th, count=4;
//    drain -> FIFO order preserved
//  4 count=2, push+pop same cycle -> count stays 2; repeat 2*DEPTH cycles to cover pointer wrap
//  5 push V=1 entry -> sticky_v=1; clr_sticky with simultaneous V=1 push -> sticky_v=0
//  6 assert rst with count=3 mid-stream -> out_valid=0, count=0 immediately; first post-reset
//    push emerges correctly

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: status flag bit positions and the packed flag struct
// carried alongside every queued result.
package alu_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

  // Field order puts v at bit 3 and z at bit 0, matching the FLAG_* indices.
  typedef struct packed {
    logic v;
    logic n;
    logic c;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V derivation from an adder/subtractor result, its raw
// carry_out and the operand sign bits.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  result,
  input  logic              carry,
  input  logic              sub,
  input  logic              a_msb,
  input  logic              b_msb,
  output logic [FLAG_W-1:0] flags
);

  alu_flags_t f;

  // b_msb is the operand before inversion, so subtraction overflows when the
  // operand signs differ and the result sign disagrees with a.
  always_comb begin
    f   = '0;
    f.z = (result == '0);
    f.n = result[WIDTH-1];
    f.c = carry;
    if (sub) f.v = (a_msb != b_msb) && (f.n != a_msb);
    else     f.v = (a_msb == b_msb) && (f.n != a_msb);
  end

  assign flags = f;

endmodule

// File: rtl/alu_result_queue.sv
// Buffers adder/subtractor results with their status flags in a small FIFO and
// tracks a sticky overflow indicator for the consumer.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_sub,
  input  logic                     in_a_msb,
  input  logic                     in_b_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [FLAG_W-1:0]        out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_v,
  input  logic                     clr_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + FLAG_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and data is stable while valid is held.
  logic              push;
  logic              pop;
  logic [FLAG_W-1:0] new_flags;
  alu_flags_t        new_f;
  logic [EW-1:0]     head;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (in_result),
    .carry  (in_carry),
    .sub    (in_sub),
    .a_msb  (in_a_msb),
    .b_msb  (in_b_msb),
    .flags  (new_flags)
  );

  assign new_f     = new_flags;
  assign in_ready  = (cnt < DEPTH_C);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  // Empty queue never pops, so a push into an empty queue only shows next cycle.
  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head[EW-1:FLAG_W] : '0;
  assign out_flags  = out_valid ? head[FLAG_W-1:0]  : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_result, new_flags};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Clear has priority over a same-cycle overflow push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sticky_v <= 1'b0;
    else if (clr_sticky)      sticky_v <= 1'b0;
    else if (push && new_f.v) sticky_v <= 1'b1;
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized and directed bench for alu_result_queue against a queue-based
// model that derives flags from signed/unsigned arithmetic on the operands.
module tb_alu_result_queue;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_result = '0;
  logic       in_carry = 1'b0;
  logic       in_sub = 1'b0;
  logic       in_a_msb = 1'b0;
  logic       in_b_msb = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [2:0] count;
  logic       sticky_v;
  logic       clr_sticky = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] exp_q[$];
  logic       m_sticky = 1'b0;

  alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_carry   (in_carry),
    .in_sub     (in_sub),
    .in_a_msb   (in_a_msb),
    .in_b_msb   (in_b_msb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .count      (count),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: arithmetic on the operands, flags from value ranges.
  function automatic logic [8:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic sub);
    int ua, ub, sa, sb, r;
    logic [3:0] res;
    logic carry, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    if (sub) begin
      res   = 4'((ua - ub + 16) % 16);
      carry = (ua >= ub);
      r     = sa - sb;
    end else begin
      res   = 4'((ua + ub) % 16);
      carry = (ua + ub) > 15;
      r     = sa + sb;
    end
    v = (r < -8) || (r > 7);
    // {carry, result, V, N, C, Z}
    return {carry, res, v, res[3], carry, (res == 4'd0)};
  endfunction

  task automatic check_outputs();
    logic [7:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check("out_valid",  {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    check("out_result", {28'd0, out_result}, {28'd0, h[7:4]});
    check("out_flags",  {28'd0, out_flags},  {28'd0, h[3:0]});
    check("count",      {29'd0, count},      32'(exp_q.size()));
    check("in_ready",   {31'd0, in_ready},   {31'd0, exp_q.size() < DEPTH});
    check("sticky_v",   {31'd0, sticky_v},   {31'd0, m_sticky});
  endtask

  // driver: one clock of stimulus, model update at the edge, check at negedge
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic sub, input logic ordy, input logic clr);
    logic [8:0] r;
    logic push_m, pop_m;
    r          = ref_op(a, b, sub);
    in_valid   = v;
    in_result  = r[7:4];
    in_carry   = r[8];
    in_sub     = sub;
    in_a_msb   = a[3];
    in_b_msb   = b[3];
    out_ready  = ordy;
    clr_sticky = clr;
    push_m = v && (exp_q.size() < DEPTH);
    pop_m  = ordy && (exp_q.size() > 0);
    @(posedge clk);
    if (pop_m)  void'(exp_q.pop_front());
    if (push_m) exp_q.push_back(r[7:0]);
    if (clr) m_sticky = 1'b0;
    else if (push_m && r[3]) m_sticky = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'd0, 4'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
  endtask

  initial begin
    // reset values while rst is held
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // add 0111+0001 -> 1000, V=1 N=1 C=0 Z=0
    cycle(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("add_res",   {28'd0, out_result}, 32'h8);
    check("add_flags", {28'd0, out_flags},  32'b1100);
    drain();

    // sub 0101-0101 -> 0000 Z=1 C=1; sub 0011-0101 -> 1110 N=1
    cycle(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0);
    check("sub0_res",   {28'd0, out_result}, 32'h0);
    check("sub0_flags", {28'd0, out_flags},  32'b0011);
    cycle(1'b1, 4'b0011, 4'b0101, 1'b1, 1'b1, 1'b0);
    check("subn_res",   {28'd0, out_result}, 32'he);
    check("subn_flags", {28'd0, out_flags},  32'b0100);
    drain();

    // fill with 5 pushes, consumer stalled
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 4'(i + 1), 4'(i + 2), 1'b0, 1'b0, 1'b0);
    check("full_count", {29'd0, count},    32'd4);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    drain();

    // steady push+pop at count=2, long enough for pointer wrap
    cycle(1'b1, 4'd3, 4'd9, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd12, 4'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++)
      cycle(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("steady_count", {29'd0, count}, 32'd2);
    drain();

    // sticky set, then clear wins over simultaneous V=1 push
    cycle(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0);
    check("sticky_set", {31'd0, sticky_v}, 32'd1);
    cycle(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b1, 1'b1);
    check("sticky_clr", {31'd0, sticky_v}, 32'd0);
    drain();

    // reset mid-stream with three entries held
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'(i * 5), 4'(i + 7), 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, count},     32'd0);
    exp_q.delete();
    m_sticky = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0);
    check("post_rst_res",   {28'd0, out_result}, 32'h7);
    check("post_rst_flags", {28'd0, out_flags},  32'b1010);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
